iomem_ram: RTL and testbench
============================

IOMEM_RAM -- requirements
Module: iomem_ram

Interface
REQ-001 The block SHALL provide parameter DEPTH_WORDS, default 1024, the number of 32-bit words stored; it SHALL be a power of two, at least 2.
REQ-002 The block SHALL provide parameter WAIT_CYCLES, default 2, the number of wait states inserted before each response; 0 is legal.
REQ-003 The block SHALL provide parameter BASE_ADDR, default 32'h0000_0000, the byte address of word 0; it SHALL be DEPTH_WORDS*4 aligned.
REQ-004 Port clk, input, 1: clock; all logic is rising-edge.
REQ-005 Port reset, input, 1: reset, synchronous, active-low.
REQ-006 Port iomem_addr, input, 32: byte address of the request; bits [1:0] ignored.
REQ-007 Port iomem_wdata, input, 32: write data.
REQ-008 Port iomem_wen, input, 1: single-cycle write request pulse.
REQ-009 Port iomem_ren, input, 1: single-cycle read request pulse.
REQ-010 Port iomem_rdata, output, 32: read data, registered.
REQ-011 Port iomem_ready, output, 1: single-cycle completion pulse, registered.

Function
REQ-012 The block SHALL be the memory-side responder of the iomem protocol: the initiator asserts iomem_wen or iomem_ren for exactly one cycle and waits for iomem_ready.
REQ-013 FSM states SHALL be IDLE, WAIT, RESP.
REQ-014 In IDLE, a cycle with iomem_wen|iomem_ren SHALL capture addr, wdata and op type into internal registers; the initiator does not have to hold them afterwards.
REQ-015 IDLE SHALL go to WAIT with wait counter loaded with WAIT_CYCLES-1 when WAIT_CYCLES>0, else directly to RESP.
REQ-016 WAIT SHALL decrement the counter each cycle and go to RESP on the cycle the counter is 0.
REQ-017 On the edge entering RESP, a write SHALL update the addressed word and a read SHALL load iomem_rdata from the addressed word.
REQ-018 iomem_ready SHALL be 1 during exactly the one RESP cycle; RESP SHALL always return to IDLE.
REQ-019 Latency: for a request in cycle N, iomem_ready SHALL be high in cycle N+1+WAIT_CYCLES.
REQ-020 iomem_rdata SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-021 iomem_wen and iomem_ren asserted together SHALL be treated as a write only.
REQ-022 Request pulses in WAIT or RESP SHALL be ignored (no capture, no second response); the earliest accepted follow-on request is the cycle after iomem_ready.
REQ-023 Word index SHALL be (iomem_addr - BASE_ADDR) >> 2, modulo 32-bit arithmetic.
REQ-024 Memory contents SHALL NOT be initialised by reset; an unwritten read returns an undefined value.

Reset
REQ-025 While reset=0 at a clock edge: state=IDLE, counter=0, iomem_ready=0, iomem_rdata=32'h0.
REQ-026 Reset asserted in WAIT or RESP SHALL abort the transaction: a pending write is not committed, no iomem_ready pulse is produced afterwards.
REQ-027 A request pulse coincident with reset=0 SHALL be ignored.

Configuration
REQ-028 Macro IOMEM_RAM_RANGE_CHECK_EN SHALL select address range checking.
REQ-029 Without the macro, the word index SHALL be taken modulo DEPTH_WORDS, so addresses outside the window alias into it.
REQ-030 With the macro, a request whose index is >= DEPTH_WORDS SHALL still complete with normal latency, but writes SHALL be discarded and reads SHALL return 32'hDEAD_BEEF.

Verification
REQ-031 WAIT_CYCLES=2: write 32'h1234_5678 to 0x10 in cycle 5 -> ready high in cycle 8 only; read 0x10 issued in cycle 9 -> ready in cycle 12 with rdata 32'h1234_5678.
REQ-032 WAIT_CYCLES=0: read pulse in cycle N -> ready in cycle N+1; back-to-back write/read at N+2 and N+4 -> each completes one cycle later, with correct data.
REQ-033 Extra ren pulse during WAIT -> exactly one ready pulse, and rdata from the original address.
REQ-034 wen and ren both high, wdata 32'hA5A5_A5A5 to 0x20 -> rdata unchanged at ready; a later read of 0x20 returns 32'hA5A5_A5A5.
REQ-035 Reset pulsed in WAIT of a write of 32'hFFFF_FFFF over 32'h0 -> no ready, iomem_rdata=0; a later read returns 32'h0.
REQ-036 DEPTH_WORDS=1024, read 0x1000 after write 32'h55 to 0x0 -> 32'h55 without the macro, 32'hDEAD_BEEF with IOMEM_RAM_RANGE_CHECK_EN.

Source files
------------

// File: rtl/iomem_ram.sv
// rtl/iomem_ram.sv - single-port word RAM responding on the iomem request/ready protocol
//
// Purpose: memory-side responder. A one-cycle iomem_wen/iomem_ren pulse is
// captured in IDLE. After WAIT_CYCLES wait states the access is performed on
// the edge entering RESP, and iomem_ready pulses for that one RESP cycle.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES  wait states before each response (0 allowed)
//   BASE_ADDR    byte address of word 0 (DEPTH_WORDS*4 aligned)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   iomem_addr   request byte address (bits [1:0] ignored)
//   iomem_wdata  write data
//   iomem_wen    write request pulse (wins over iomem_ren)
//   iomem_ren    read request pulse
//   iomem_rdata  registered read data, held until the next read completes
//   iomem_ready  registered one-cycle completion pulse
//
// Configuration macro: IOMEM_RAM_RANGE_CHECK_EN
//   undefined: word index wraps modulo DEPTH_WORDS (addresses alias)
//   defined:   out-of-range writes are dropped, out-of-range reads return 32'hDEAD_BEEF

module iomem_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    input  logic        iomem_wen,
    input  logic        iomem_ren,
    output logic [31:0] iomem_rdata,
    output logic        iomem_ready
);

    localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          CW         = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned CNT_LOAD   = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;
    localparam logic [31:0] OOR_RDATA  = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           op_wr_q;
    logic [29:0]    word_q;
    logic [31:0]    wdata_q;
    logic [31:0]    rdata_q;
    logic           ready_q;

    logic [31:0]    mem [DEPTH_WORDS];

    // Word index relative to the window base, modulo 2^32.
    logic [31:0]    req_off;
    logic [29:0]    req_word;
    logic           req_any;

    assign req_off  = iomem_addr - BASE_ADDR;
    assign req_word = req_off[31:2];
    assign req_any  = iomem_wen | iomem_ren;

    // Access performed on the edge entering RESP. With zero wait states that
    // edge is the capture edge itself, so the live request is used instead of
    // the captured copy.
    logic           acc_go_d;
    logic           acc_wr_d;
    logic [29:0]    acc_word_d;
    logic [31:0]    acc_wdata_d;
    logic [AW-1:0]  acc_idx_d;
    logic           acc_ok_d;
    logic [31:0]    acc_rdata_d;

    always_comb begin
        acc_go_d    = 1'b0;
        acc_wr_d    = op_wr_q;
        acc_word_d  = word_q;
        acc_wdata_d = wdata_q;
        if (state_q == IDLE) begin
            acc_go_d    = req_any && (WAIT_CYCLES == 0);
            acc_wr_d    = iomem_wen;
            acc_word_d  = req_word;
            acc_wdata_d = iomem_wdata;
        end else if (state_q == WAIT) begin
            acc_go_d    = (cnt_q == '0);
        end
    end

    assign acc_idx_d = acc_word_d[AW-1:0];

`ifdef IOMEM_RAM_RANGE_CHECK_EN
    assign acc_ok_d    = ({2'b00, acc_word_d} < DEPTH_WORDS);
    assign acc_rdata_d = acc_ok_d ? mem[acc_idx_d] : OOR_RDATA;
`else
    assign acc_ok_d    = 1'b1;
    assign acc_rdata_d = mem[acc_idx_d];
`endif

    // Storage is never reset; a write is only committed when reset is
    // deasserted on the commit edge, so a reset in WAIT drops it.
    always_ff @(posedge clk) begin
        if (reset && acc_go_d && acc_wr_d && acc_ok_d) begin
            mem[acc_idx_d] <= acc_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        op_wr_q <= iomem_wen;
                        word_q  <= req_word;
                        wdata_q <= iomem_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CW'(CNT_LOAD);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (acc_go_d) begin
                ready_q <= 1'b1;
                if (!acc_wr_d) begin
                    rdata_q <= acc_rdata_d;
                end
            end
        end
    end

    assign iomem_rdata = rdata_q;
    assign iomem_ready = ready_q;

endmodule

// File: tb/tb_iomem_ram.sv
// tb/tb_iomem_ram.sv - scoreboard bench for iomem_ram with 2 and 0 wait states

module tb_iomem_ram;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    int unsigned cyc;
    int          n_vec;
    int          n_fail;

    logic        rst_a, a_wen, a_ren, a_ready;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        rst_b, b_wen, b_ren, b_ready;
    logic [31:0] b_addr, b_wdata, b_rdata;

    exp_t qa[$];
    exp_t qb[$];

    iomem_ram #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut_a (
        .clk        (clk),
        .reset      (rst_a),
        .iomem_addr (a_addr),
        .iomem_wdata(a_wdata),
        .iomem_wen  (a_wen),
        .iomem_ren  (a_ren),
        .iomem_rdata(a_rdata),
        .iomem_ready(a_ready)
    );

    iomem_ram #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_b (
        .clk        (clk),
        .reset      (rst_b),
        .iomem_addr (b_addr),
        .iomem_wdata(b_wdata),
        .iomem_wen  (b_wen),
        .iomem_ren  (b_ren),
        .iomem_rdata(b_rdata),
        .iomem_ready(b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ready pulse must match the head of its DUT's queue.
    always @(negedge clk) begin
        exp_t e;
        if (a_ready) begin
            if (qa.size() == 0) begin
                n_vec++; n_fail++;
                $display("FAIL a_spurious_ready: ready=1 at cycle %0d, required 0", cyc);
            end else begin
                e = qa.pop_front();
                n_vec++;
                if (cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL a_latency: ready at cycle %0d, required cycle %0d", cyc, e.cyc);
                end
                n_vec++;
                if (a_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL a_rdata: got %h, required %h (cycle %0d)", a_rdata, e.data, cyc);
                end
            end
        end
        if (b_ready) begin
            if (qb.size() == 0) begin
                n_vec++; n_fail++;
                $display("FAIL b_spurious_ready: ready=1 at cycle %0d, required 0", cyc);
            end else begin
                e = qb.pop_front();
                n_vec++;
                if (cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL b_latency: ready at cycle %0d, required cycle %0d", cyc, e.cyc);
                end
                n_vec++;
                if (b_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL b_rdata: got %h, required %h (cycle %0d)", b_rdata, e.data, cyc);
                end
            end
        end
    end

    task automatic wait_to(input int unsigned n);
        while (cyc != n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a one-cycle request on DUT sel (0=A, 1=B); optionally record the
    // expected response.
    task automatic req(input int sel, input logic wen, input logic ren,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit push, input logic [31:0] exp_data);
        exp_t e;
        if (sel == 0) begin
            a_wen = wen; a_ren = ren; a_addr = addr; a_wdata = wdata;
        end else begin
            b_wen = wen; b_ren = ren; b_addr = addr; b_wdata = wdata;
        end
        if (push) begin
            e.cyc  = cyc + 1 + ((sel == 0) ? 2 : 0);
            e.data = exp_data;
            if (sel == 0) qa.push_back(e);
            else          qb.push_back(e);
        end
        @(posedge clk);
        #1;
        a_wen = 1'b0; a_ren = 1'b0;
        b_wen = 1'b0; b_ren = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_vec++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d responses outstanding, required 0", tag, qa.size() + qb.size());
            qa.delete();
            qb.delete();
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    logic [31:0] alias_exp;
    logic [31:0] oob_exp;
    int unsigned c;

    initial begin
        n_vec = 0; n_fail = 0;
        rst_a = 1'b0; rst_b = 1'b0;
        a_wen = 1'b0; a_ren = 1'b0; a_addr = '0; a_wdata = '0;
        b_wen = 1'b0; b_ren = 1'b0; b_addr = '0; b_wdata = '0;
`ifdef IOMEM_RAM_RANGE_CHECK_EN
        oob_exp   = 32'hDEAD_BEEF;
        alias_exp = 32'h0000_0011;
`else
        oob_exp   = 32'h0000_0055;
        alias_exp = 32'h0000_0099;
`endif

        wait_to(1);
        check("a_reset_rdata", a_rdata, 32'h0);
        check("a_reset_ready", {31'b0, a_ready}, 32'h0);
        check("b_reset_rdata", b_rdata, 32'h0);
        check("b_reset_ready", {31'b0, b_ready}, 32'h0);
        wait_to(2);
        rst_a = 1'b1; rst_b = 1'b1;

        // Two wait states: write in cycle 5 -> ready 8; read in cycle 9 -> ready 12.
        wait_to(5);
        req(0, 1, 0, 32'h10, 32'h1234_5678, 1, 32'h0);
        wait_to(9);
        req(0, 0, 1, 32'h10, 32'h0, 1, 32'h1234_5678);
        wait_idle("a_basic");

        // Extra pulses in WAIT and RESP are ignored; follow-on right after ready.
        req(0, 1, 0, 32'h30, 32'hCAFE_0001, 1, 32'h1234_5678);
        wait_idle("a_wr30");
        c = cyc;
        req(0, 0, 1, 32'h30, 32'h0, 1, 32'hCAFE_0001);
        req(0, 0, 1, 32'h10, 32'h0, 0, 32'h0);
        wait_to(c + 3);
        req(0, 1, 0, 32'h10, 32'h0000_0BAD, 0, 32'h0);
        req(0, 0, 1, 32'h10, 32'h0, 1, 32'h1234_5678);
        wait_idle("a_ignore");

        // wen and ren together act as a write.
        req(0, 1, 1, 32'h20, 32'hA5A5_A5A5, 1, 32'h1234_5678);
        wait_idle("a_both");
        req(0, 0, 1, 32'h20, 32'h0, 1, 32'hA5A5_A5A5);
        wait_idle("a_both_rd");

        // Window boundary: last word, aliasing / range check above 0x1000.
        req(0, 1, 0, 32'hFFC, 32'h0000_0FFC, 1, 32'hA5A5_A5A5);
        req(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        wait_idle("a_wrlast");
        req(0, 0, 1, 32'hFFC, 32'h0, 1, 32'h0000_0FFC);
        wait_idle("a_rdlast");
        req(0, 1, 0, 32'h0, 32'h0000_0055, 1, 32'h0000_0FFC);
        wait_idle("a_wr0");
        req(0, 0, 1, 32'h1000, 32'h0, 1, oob_exp);
        wait_idle("a_rd1000");
        req(0, 1, 0, 32'h4, 32'h0000_0011, 1, oob_exp);
        wait_idle("a_wr4");
        req(0, 1, 0, 32'h1004, 32'h0000_0099, 1, oob_exp);
        wait_idle("a_wr1004");
        req(0, 0, 1, 32'h4, 32'h0, 1, alias_exp);
        wait_idle("a_rd4");

        // Reset during WAIT aborts a pending write and produces no ready.
        req(0, 1, 0, 32'h40, 32'h0, 1, alias_exp);
        wait_idle("a_wr40");
        req(0, 1, 0, 32'h40, 32'hFFFF_FFFF, 0, 32'h0);
        rst_a = 1'b0;
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        check("a_abort_rdata", a_rdata, 32'h0);
        check("a_abort_ready", {31'b0, a_ready}, 32'h0);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        req(0, 0, 1, 32'h40, 32'h0, 1, 32'h0);
        wait_idle("a_rd40");

        // Zero wait states: one-cycle latency, back-to-back every other cycle.
        c = cyc + 2;
        wait_to(c);
        req(1, 1, 0, 32'h8, 32'h0000_B0B0, 1, 32'h0);
        req(1, 0, 1, 32'hC, 32'h0, 0, 32'h0);
        req(1, 0, 1, 32'h8, 32'h0, 1, 32'h0000_B0B0);
        wait_to(c + 4);
        req(1, 1, 0, 32'hC, 32'h0000_1111, 1, 32'h0000_B0B0);
        wait_to(c + 6);
        req(1, 0, 1, 32'hC, 32'h0, 1, 32'h0000_1111);
        wait_idle("b_b2b");

        repeat (4) begin
            @(posedge clk);
            #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
